// File: rtl/alib_ram_pkg.sv
// alib_ram_pkg: shared types and helpers for the alib simple-dual-port RAM.
// Holds the controller state encoding and the address-width helper.
package alib_ram_pkg;

  // Controller states: INIT runs the clear sweep, READY serves user traffic.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_t;

  // Number of address bits needed to index 'depth' words (never below 1).
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/alib_ram_core.sv
// alib_ram_core: storage array with one byte-enabled write port and one
// registered read port. No reset on the array or the read register so the
// tools can map it onto block or ultra RAM as selected by RAM_STYLE.
module alib_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter     RAM_STYLE  = "block",
  localparam int NBE       = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [NBE-1:0]        wbe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write; lanes with a clear enable keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NBE; i++) begin
        if (wbe[i]) begin
          mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Registered read; the register only moves on a read so it holds otherwise.
  // A same-edge write to the same word is not visible here (old data returned).
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/alib_ram_sdp.sv
// alib_ram_sdp: simple-dual-port RAM with a clear sweep after reset or on
// request, byte-enabled writes, and 1- or 2-cycle read latency.
// Optional macro ALIB_RAM_SDP_FWD_EN: a read and a write to the same word in
// the same cycle return the newly written lanes merged with the old lanes.
// Without the macro the read returns the pre-write contents.
// rst is asynchronous and active low.
module alib_ram_sdp
  import alib_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    DEPTH        = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter                        RAM_STYLE    = "block",
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  localparam int                   NBE          = DATA_WIDTH / BYTE_WIDTH,
  localparam int                   ADDR_WIDTH   = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [NBE-1:0]        wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  ram_state_t            state_reg;
  logic                  busy_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_acc;
  logic                  rd_acc;

  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [NBE-1:0]        core_wbe;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_re;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  rd_v1_reg;
  logic                  rd_oor_reg;
  logic                  rd_zero_reg;
  logic [DATA_WIDTH-1:0] fwd_word;
  logic [DATA_WIDTH-1:0] rd_word;

  // Addresses past the last word exist only when DEPTH is not a power of two.
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

  // User traffic is only accepted once the sweep has finished.
  assign wr_acc = (state_reg == READY) && wr_en && wr_in_range;
  assign rd_acc = (state_reg == READY) && rd_en;

  // The sweep owns the write port while INIT; otherwise the user does.
  assign core_we    = (state_reg == INIT) || wr_acc;
  assign core_waddr = (state_reg == INIT) ? cnt_reg : wr_addr;
  assign core_wbe   = (state_reg == INIT) ? {NBE{1'b1}} : wr_be;
  assign core_wdata = (state_reg == INIT) ? INIT_VALUE : wr_data;
  assign core_re    = rd_acc && rd_in_range;

  assign busy = busy_reg;

  alib_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_STYLE  (RAM_STYLE)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .waddr (core_waddr),
    .wbe   (core_wbe),
    .wdata (core_wdata),
    .re    (core_re),
    .raddr (rd_addr),
    .rdata (core_rdata)
  );

  // Sweep controller: one word per cycle, then READY; init_req is only
  // honoured in READY so a request during a sweep never restarts the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= INIT;
      busy_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        INIT: begin
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= READY;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + ADDR_WIDTH'(1);
          end
        end
        READY: begin
          if (init_req) begin
            state_reg <= INIT;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= INIT;
          busy_reg  <= 1'b1;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // First read stage, aligned with the core read register. rd_zero_reg keeps
  // the output at zero after reset until the first read returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1_reg   <= 1'b0;
      rd_oor_reg  <= 1'b0;
      rd_zero_reg <= 1'b1;
    end else begin
      rd_v1_reg <= rd_acc;
      if (rd_acc) begin
        rd_oor_reg  <= !rd_in_range;
        rd_zero_reg <= 1'b0;
      end
    end
  end

`ifdef ALIB_RAM_SDP_FWD_EN
  logic [NBE-1:0]        fwd_be_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  // Capture the lanes written in the same cycle as a read of the same word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_be_reg   <= '0;
      fwd_data_reg <= '0;
    end else if (rd_acc) begin
      fwd_be_reg   <= (wr_acc && (wr_addr == rd_addr)) ? wr_be : '0;
      fwd_data_reg <= wr_data;
    end
  end

  genvar gi;
  for (gi = 0; gi < NBE; gi++) begin : g_fwd_lane
    assign fwd_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
      fwd_be_reg[gi] ? fwd_data_reg[gi*BYTE_WIDTH +: BYTE_WIDTH]
                     : core_rdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end
`else
  assign fwd_word = core_rdata;
`endif

  // Final read word: reset value, out-of-range substitute, or stored data.
  always_comb begin
    rd_word = fwd_word;
    if (rd_oor_reg) begin
      rd_word = INIT_VALUE;
    end
    if (rd_zero_reg) begin
      rd_word = '0;
    end
  end

  // Output stage: latency 2 adds one register, any other value behaves as 1.
  if (READ_LATENCY == 2) begin : g_lat2
    logic                  rd_v2_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Second read stage; data only updates when a result moves through.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_v2_reg   <= 1'b0;
        rd_data_reg <= '0;
      end else begin
        rd_v2_reg <= rd_v1_reg;
        if (rd_v1_reg) begin
          rd_data_reg <= rd_word;
        end
      end
    end

    assign rd_valid = rd_v2_reg;
    assign rd_data  = rd_data_reg;
  end else begin : g_lat1
    assign rd_valid = rd_v1_reg;
    assign rd_data  = rd_word;
  end

endmodule

// File: tb/tb_alib_ram_sdp.sv
// tb_alib_ram_sdp: drives one latency-1 and one latency-2 instance with the
// same stimulus; a reference memory model feeds per-instance expectation
// queues that are checked when each instance raises rd_valid.
module tb_alib_ram_sdp;

  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          NBE   = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INITV = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init_req = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NBE-1:0] wr_be = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          busy1, busy2, rd_valid1, rd_valid2;
  logic [DW-1:0] rd_data1, rd_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;
  logic [DW-1:0] model [DEPTH];
  bit            model_busy = 1'b1;

  alib_ram_sdp #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(DEPTH), .READ_LATENCY(1),
    .RAM_STYLE("block"), .INIT_VALUE(INITV)
  ) dut1 (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
  );

  alib_ram_sdp #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(DEPTH), .READ_LATENCY(2),
    .RAM_STYLE("block"), .INIT_VALUE(INITV)
  ) dut2 (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-instance output check, run on every falling edge out of reset.
  task automatic mon(input int idx, input logic v, input logic [DW-1:0] d);
    exp_t  e;
    bit    have;
    string nm;
    nm   = (idx == 1) ? "lat1" : "lat2";
    have = (idx == 1) ? (q1.size() != 0) : (q2.size() != 0);
    if (v) begin
      check({nm, " valid_expected"}, 32'(have), 32'd1);
      if (have) begin
        if (idx == 1) e = q1.pop_front();
        else          e = q2.pop_front();
        check({nm, " latency"}, 32'(cyc), 32'(e.due));
        check({nm, " rd_data"}, d, e.data);
        $display("read done %s cyc=%0d data=%h", nm, cyc, d);
      end
      if (idx == 1) last1 = d;
      else          last2 = d;
    end else begin
      if (have) begin
        e = (idx == 1) ? q1[0] : q2[0];
        if (cyc > e.due) begin
          check({nm, " valid_missing"}, 32'(cyc), 32'(e.due));
          if (idx == 1) void'(q1.pop_front());
          else          void'(q2.pop_front());
        end
      end
      check({nm, " hold"}, d, (idx == 1) ? last1 : last2);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
    end else begin
      mon(1, rd_valid1, rd_data1);
      mon(2, rd_valid2, rd_data2);
    end
  end

  // One cycle of stimulus, starting and ending on a falling edge.
  task automatic step(input bit we, input int wa, input logic [3:0] be, input logic [31:0] wd,
                      input bit re, input int ra, input bit ini);
    logic [31:0] e;
    wr_en = we; wr_addr = AW'(wa); wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = AW'(ra); init_req = ini;
    $display("step cyc=%0d we=%0b wa=%0d be=%h wd=%h re=%0b ra=%0d init=%0b",
             cyc, we, wa, be, wd, re, ra, ini);
    if (!model_busy) begin
      if (re) begin
        e = model[ra];
`ifdef ALIB_RAM_SDP_FWD_EN
        if (we && (wa == ra)) begin
          for (int i = 0; i < NBE; i++) if (be[i]) e[i*8 +: 8] = wd[i*8 +: 8];
        end
`endif
        q1.push_back(exp_t'{e, cyc + 1});
        q2.push_back(exp_t'{e, cyc + 2});
      end
      if (we) begin
        for (int i = 0; i < NBE; i++) if (be[i]) model[wa][i*8 +: 8] = wd[i*8 +: 8];
      end
      if (ini) model_busy = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; init_req = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  // Counts cycles until busy drops; optionally pokes user traffic mid-sweep.
  task automatic wait_sweep(input bit poke, output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 64) begin
      if (poke && n == 4) begin
        init_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'hF;
        wr_data = 32'h0BAD0BAD; rd_en = 1'b1; rd_addr = 4'd9;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    end
    $display("sweep done cyc=%0d length=%0d", cyc, n);
    for (int i = 0; i < DEPTH; i++) model[i] = INITV;
    model_busy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy1"}, 32'(busy1), 32'd1);
    check({tag, " busy2"}, 32'(busy2), 32'd1);
    check({tag, " rd_valid1"}, 32'(rd_valid1), 32'd0);
    check({tag, " rd_valid2"}, 32'(rd_valid2), 32'd0);
    check({tag, " rd_data1"}, rd_data1, 32'h0);
    check({tag, " rd_data2"}, rd_data2, 32'h0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Release reset: full clear sweep, then read every word.
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    wait_sweep(1'b0, n);
    check("sweep_len_release", 32'(n), 32'd16);
    check("busy2_after_sweep", 32'(busy2), 32'd0);
    for (int a = 0; a < DEPTH; a++) step(1'b0, 0, 4'h0, 32'h0, 1'b1, a, 1'b0);
    idle(3);

    // Byte-enable merge.
    step(1'b1, 3, 4'hF, 32'h11223344, 1'b0, 0, 1'b0);
    step(1'b1, 3, 4'h2, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 3, 1'b0);
    idle(3);

    // Distinct words then back-to-back reads.
    step(1'b1, 0, 4'hF, 32'h00001000, 1'b0, 0, 1'b0);
    step(1'b1, 1, 4'hF, 32'h00001001, 1'b0, 0, 1'b0);
    step(1'b1, 2, 4'hF, 32'h00001002, 1'b0, 0, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 0, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 1, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 2, 1'b0);
    idle(3);

    // Same-cycle read and write of one word, full and partial lanes.
    step(1'b1, 5, 4'hF, 32'h00000000, 1'b0, 0, 1'b0);
    step(1'b1, 5, 4'hF, 32'hDEADBEEF, 1'b1, 5, 1'b0);
    step(1'b1, 5, 4'h1, 32'h000000EE, 1'b1, 5, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 5, 1'b0);
    idle(3);

    // Clear request with a read in flight; mid-sweep traffic is ignored.
    step(1'b1, 9, 4'hF, 32'h00000055, 1'b0, 0, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 9, 1'b1);
    wait_sweep(1'b1, n);
    check("sweep_len_init_req", 32'(n), 32'd16);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 9, 1'b0);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 3, 1'b0);
    idle(3);

    // Reset with a read still in the latency-2 pipeline.
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 7, 1'b0);
    #2 rst = 1'b0; model_busy = 1'b1;
    #1 check_reset_outputs("reset_mid_read");
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    wait_sweep(1'b0, n);
    check("sweep_len_after_read_abort", 32'(n), 32'd16);
    step(1'b0, 0, 4'h0, 32'h0, 1'b1, 2, 1'b0);
    idle(3);

    // Reset while the sweep is at address 7.
    step(1'b0, 0, 4'h0, 32'h0, 1'b0, 0, 1'b1);
    repeat (7) @(posedge clk);
    #2 rst = 1'b0; model_busy = 1'b1;
    #1 check_reset_outputs("reset_mid_sweep");
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    wait_sweep(1'b0, n);
    check("sweep_len_after_sweep_abort", 32'(n), 32'd16);
    for (int a = 0; a < 4; a++) step(1'b0, 0, 4'h0, 32'h0, 1'b1, a, 1'b0);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alib_ram_sdp.md
ALIB_RAM_SDP -- requirements
Module: alib_ram_sdp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (multiple of BYTE_WIDTH).
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, write-enable granularity in bits; NBE = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words (>= 2); ADDR_WIDTH = clog2(DEPTH).
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from accepted read to rd_valid.
REQ-005 SHALL have parameter RAM_STYLE, default "block", storage inference hint ("block" or "ultra").
REQ-006 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH word written by the clear sweep.
REQ-007 SHALL have ports: clk in 1 sole clock, rising edge; rst in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: init_req in 1 start clear sweep; busy out 1 sweep in progress.
REQ-009 SHALL have ports: wr_en in 1; wr_addr in ADDR_WIDTH; wr_be in NBE byte enables; wr_data in DATA_WIDTH.
REQ-010 SHALL have ports: rd_en in 1; rd_addr in ADDR_WIDTH; rd_data out DATA_WIDTH; rd_valid out 1.

Function
REQ-011 SHALL implement FSM states INIT and READY; rst release enters INIT, sweep end enters READY, init_req in READY enters INIT.
REQ-012 In INIT SHALL write INIT_VALUE to one address per cycle, counter 0..DEPTH-1, busy=1, then READY on cycle after address DEPTH-1 (sweep = DEPTH cycles).
REQ-013 init_req while INIT SHALL be ignored (no counter restart).
REQ-014 In INIT user wr_en and rd_en SHALL be ignored; no memory change from user port, rd_valid=0 for those requests.
REQ-015 In READY, wr_en=1 SHALL write each byte lane i of wr_data where wr_be[i]=1; lanes with wr_be[i]=0 unchanged.
REQ-016 In READY, rd_en=1 SHALL produce rd_data for rd_addr with rd_valid=1 exactly READ_LATENCY cycles later, one-cycle pulse per request, back-to-back reads every cycle.
REQ-017 rd_data SHALL hold last valid value when rd_valid=0 (no gating to zero).
REQ-018 Same-cycle read and write to same address, macro absent: read SHALL return old (pre-write) contents.
REQ-019 Addresses >= DEPTH (non-power-of-two DEPTH) SHALL drop writes and return INIT_VALUE on reads with rd_valid=1.
REQ-020 Read requests in flight when init_req accepted SHALL complete with rd_valid=1 and pre-sweep data.

Reset
REQ-021 rst=0 SHALL immediately force busy=1, rd_valid=0, rd_data=0, pipeline valid bits=0, sweep counter=0, state=INIT.
REQ-022 Reset mid-sweep or mid-read SHALL abort; after release sweep restarts at address 0.
REQ-023 Storage array SHALL NOT be reset directly; contents defined only by completed sweep.

Configuration
REQ-024 Macro ALIB_RAM_SDP_FWD_EN defined: same-cycle same-address read/write SHALL return new data, per-lane merge (written lanes new, others old).
REQ-025 Macro absent: no forwarding logic; behaviour per REQ-018.

Structure
REQ-026 Package alib_ram_pkg SHALL hold FSM state enum (INIT, READY) and address-width helper function.
REQ-027 Storage SHALL be sub-module alib_ram_core (one write port with byte enables, one registered read port, RAM_STYLE attribute); FSM, pipeline, forwarding in alib_ram_sdp.

Verification
REQ-028 Reset release, DEPTH=16, INIT_VALUE=0xA5A5A5A5 -> busy=1 for 16 cycles, then 0; read all 16 -> 0xA5A5A5A5.
REQ-029 READY, write addr 3 data 0x11223344 be=0xF, then addr 3 data 0xFFFFFFFF be=0x2 -> read addr 3 = 0x1122FF44.
REQ-030 READ_LATENCY=2, reads addr 0,1,2 on consecutive cycles -> rd_valid high cycles 2,3,4 in order, correct data.
REQ-031 Addr 5 = 0x0, same-cycle write 0xDEADBEEF be=0xF and read addr 5 -> rd_data 0x0 (macro absent) / 0xDEADBEEF (macro defined).
REQ-032 rst=0 at sweep address 7 of 16 -> busy=1, rd_valid=0 immediately; after release sweep runs full 16 cycles from 0.
REQ-033 init_req in READY after writing addr 9 = 0x55 -> busy 16 cycles, addr 9 reads INIT_VALUE; init_req during sweep leaves length unchanged.
